spi_cmd_fifo: RTL and testbench
===============================

SPI_CMD_FIFO -- requirements
Module: spi_cmd_fifo

Interface
- REQ-001 Parameter DATA_WIDTH, default 32, command word width.
- REQ-002 Parameter FIFO_DEPTH, default 4, number of stored words; power of two, >=2.
- REQ-003 Parameter LATCH_GAP, default 2, idle cycles after each strobe; >=1.
- REQ-004 Single clock and asynchronous active-high reset: "clock input 1 rising-edge clock"; "reset input 1 async active-high reset".
- REQ-005 word_in  input  DATA_WIDTH  word delivered by the SPI receiver.
- REQ-006 word_valid  input  1  one-cycle strobe qualifying word_in.
- REQ-007 sink_ready  input  1  downstream sequencer can accept a command.
- REQ-008 status_clear  input  1  clears the sticky flags.
- REQ-009 cmd_data  output  DATA_WIDTH  command word presented to the sequencer.
- REQ-010 latch_data  output  1  one-cycle strobe telling the sequencer to take cmd_data.
- REQ-011 fifo_level  output  clog2(FIFO_DEPTH)+1  words currently stored.
- REQ-012 overflow  output  1  sticky flag: a word was dropped because the FIFO was full.
- REQ-013 parity_error  output  1  sticky flag: a word was dropped for bad parity.

Function
- REQ-014 Push: word_valid high and not full -> word stored at that edge; fifo_level +1.
- REQ-015 Full is evaluated after the same-cycle pop, so push+pop at level FIFO_DEPTH is accepted and the level is unchanged.
- REQ-016 Push while full with no pop -> word discarded, overflow set, level unchanged.
- REQ-017 No bypass: a word pushed into an empty FIFO can first be popped in the following cycle.
- REQ-018 Output FSM states: IDLE, SETUP, STROBE, GAP.
- REQ-019 IDLE: level>0 and sink_ready -> pop head into cmd_data and go to SETUP; otherwise stay. sink_ready is sampled only in IDLE.
- REQ-020 SETUP lasts 1 cycle, then STROBE.
- REQ-021 STROBE lasts 1 cycle, with latch_data=1 registered; then GAP.
- REQ-022 GAP lasts exactly LATCH_GAP cycles, counted by a down-counter, then IDLE.
- REQ-023 cmd_data changes only on a pop edge; it is stable from SETUP through the end of GAP.
- REQ-024 Latency: word_valid at cycle N, empty FIFO, FSM in IDLE, sink_ready high -> pop at cycle N+1, latch_data high in cycle N+3.
- REQ-025 Back-to-back words: strobe spacing is exactly 3+LATCH_GAP cycles.
- REQ-026 Read and write pointers wrap modulo FIFO_DEPTH; fifo_level never exceeds FIFO_DEPTH and never underflows.
- REQ-027 status_clear clears overflow and parity_error at the next edge. If status_clear and a new drop occur in the same cycle, the flag remains set.

Reset
- REQ-028 While reset is high: FSM=IDLE, pointers=0, fifo_level=0, cmd_data=0, latch_data=0, overflow=0, parity_error=0. Takes effect asynchronously, including mid-strobe.
- REQ-029 Queued words are discarded by reset. Stored data is not reset; only the pointers are.

Configuration
- REQ-030 Macro SPI_CMD_FIFO_PARITY_EN defined: a word whose XOR over all bits is 1 is discarded at push and sets parity_error. Parity is checked before the full check, so a bad word never sets overflow.
- REQ-031 Macro not defined: no parity logic is compiled, all words are accepted, and parity_error is tied 0.

Structure
- REQ-032 Shared package spi_cmd_pkg holds: the FSM state typedef, the default DATA_WIDTH/FIFO_DEPTH/LATCH_GAP constants, and the parity helper function.
- REQ-033 Storage and pointers sit in sub-module spi_cmd_fifo_store. The FSM, gap counter and flags stay in spi_cmd_fifo.

Verification
- REQ-034 Reset released, sink_ready=1, push 0x0000_00A5 at cycle 10 -> cmd_data=0x0000_00A5 from cycle 12; latch_data high only in cycle 13; fifo_level back to 0 at cycle 12.
- REQ-035 sink_ready=0, push 5 words at default depth -> fifo_level=4, overflow=1, 5th word never appears. Then sink_ready=1 -> 4 strobes spaced 5 cycles apart, in push order.
- REQ-036 Level 4, simultaneous push and pop -> level stays 4, overflow stays 0, pushed word emerges 4th after the current pop.
- REQ-037 Reset asserted during STROBE with 2 words queued -> latch_data drops without waiting for a clock edge; after release no strobe occurs and fifo_level=0.
- REQ-038 With SPI_CMD_FIFO_PARITY_EN: push 0x0000_0001 -> dropped, parity_error=1; then push 0x0000_0003 -> strobed. status_clear -> parity_error=0 next cycle. Without the macro, 0x0000_0001 is strobed.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Shared types and defaults for the SPI command FIFO.
// Holds the output FSM state type and the parity helper.
package spi_cmd_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_LATCH_GAP  = 2;

    // Words are zero-extended into this width; XOR is unaffected.
    localparam int PARITY_MAX_W = 1024;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_GAP
    } cmd_state_e;

    function automatic logic odd_parity(
        input logic [PARITY_MAX_W-1:0] w
    );
        return ^w;
    endfunction

endpackage

// File: rtl/spi_cmd_fifo_if.sv
// Word-in / command-out bundle of the SPI command FIFO.
// master = receiver+sequencer side, slave = the FIFO.
interface spi_cmd_fifo_if
    import spi_cmd_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] word_in;
    logic                  word_valid;
    logic                  sink_ready;
    logic                  status_clear;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic                  latch_data;
    logic [LVL_W-1:0]      fifo_level;
    logic                  overflow;
    logic                  parity_error;

    modport master (
        output word_in,
        output word_valid,
        output sink_ready,
        output status_clear,
        input  cmd_data,
        input  latch_data,
        input  fifo_level,
        input  overflow,
        input  parity_error
    );

    modport slave (
        input  word_in,
        input  word_valid,
        input  sink_ready,
        input  status_clear,
        output cmd_data,
        output latch_data,
        output fifo_level,
        output overflow,
        output parity_error
    );

endinterface

// File: rtl/spi_cmd_fifo_store.sv
// Word storage and wrapping pointers for the SPI command FIFO.
// Memory contents survive reset; only pointers and level clear.
module spi_cmd_fifo_store
    import spi_cmd_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int PTR_W = $clog2(FIFO_DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [LVL_W-1:0]      level,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full  = (level == LVL_W'(FIFO_DEPTH));
    assign empty = (level == '0);

    // Fullness is judged after a same-cycle pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/spi_cmd_fifo.sv
// SPI command FIFO: queues received words and strobes them out.
// Define SPI_CMD_FIFO_PARITY_EN to drop odd-parity words.
module spi_cmd_fifo
    import spi_cmd_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int LATCH_GAP  = DEF_LATCH_GAP
) (
    input logic           clock,
    input logic           reset,
    spi_cmd_fifo_if.slave bus
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int GAP_W = $clog2(LATCH_GAP + 1);

    cmd_state_e            state_q;
    cmd_state_e            state_d;
    logic [GAP_W-1:0]      gap_q;
    logic [DATA_WIDTH-1:0] cmd_q;
    logic                  latch_q;
    logic                  ovf_q;
    logic                  pop;
    logic                  push;
    logic                  drop_full;
    logic [DATA_WIDTH-1:0] head;
    logic [LVL_W-1:0]      level;
    logic                  full;
    logic                  empty;

`ifdef SPI_CMD_FIFO_PARITY_EN
    logic bad_word;
    logic par_q;

    assign bad_word = odd_parity(PARITY_MAX_W'(bus.word_in));

    // A new drop wins over a same-cycle clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= (bus.word_valid && bad_word)
                   || (par_q && !bus.status_clear);
        end
    end

    assign bus.parity_error = par_q;
`else
    localparam logic bad_word = 1'b0;

    assign bus.parity_error = 1'b0;
`endif

    assign push      = bus.word_valid && !bad_word
                     && (!full || pop);
    assign drop_full = bus.word_valid && !bad_word
                     && full && !pop;

    spi_cmd_fifo_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_store (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (bus.word_in),
        .rd_data (head),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // sink_ready only matters while idle.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty && bus.sink_ready) begin
                    pop     = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: state_d = ST_GAP;
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gap_q   <= '0;
            cmd_q   <= '0;
            latch_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            latch_q <= (state_q == ST_SETUP);
            if (pop) begin
                cmd_q <= head;
            end
            if (state_q == ST_STROBE) begin
                gap_q <= GAP_W'(LATCH_GAP - 1);
            end else if (state_q == ST_GAP && gap_q != '0) begin
                gap_q <= gap_q - GAP_W'(1);
            end
            ovf_q <= drop_full || (ovf_q && !bus.status_clear);
        end
    end

    assign bus.cmd_data   = cmd_q;
    assign bus.latch_data = latch_q;
    assign bus.fifo_level = level;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_spi_cmd_fifo.sv
// Directed bench for spi_cmd_fifo at default parameters.
// Expectations are hand-derived cycle by cycle.
module tb_spi_cmd_fifo;

    logic clock = 1'b0;
    logic reset = 1'b1;

    spi_cmd_fifo_if bus ();

    spi_cmd_fifo dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [31:0] sq_data[$];
    int          sq_cyc[$];

    always @(posedge clock) cyc = cyc + 1;

    always @(negedge clock) begin
        if (bus.latch_data === 1'b1) begin
            sq_data.push_back(bus.cmd_data);
            sq_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic push_word(input logic [31:0] w);
        bus.word_in    = w;
        bus.word_valid = 1'b1;
        tick();
        bus.word_valid = 1'b0;
    endtask

    task automatic clear_log();
        sq_data.delete();
        sq_cyc.delete();
    endtask

    task automatic test_reset();
        bus.word_in      = '0;
        bus.word_valid   = 1'b0;
        bus.sink_ready   = 1'b0;
        bus.status_clear = 1'b0;
        reset = 1'b1;
        idle(2);
        checks++;
        if (bus.fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL rst_level got=%0d exp=0", bus.fifo_level);
        end
        checks++;
        if (bus.cmd_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_cmd got=%h exp=0", bus.cmd_data);
        end
        checks++;
        if (bus.latch_data !== 1'b0) begin
            errors++;
            $display("FAIL rst_latch got=%b exp=0", bus.latch_data);
        end
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL rst_ovf got=%b exp=0", bus.overflow);
        end
        checks++;
        if (bus.parity_error !== 1'b0) begin
            errors++;
            $display("FAIL rst_par got=%b exp=0", bus.parity_error);
        end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_latency();
        int n0;
        bus.sink_ready = 1'b1;
        clear_log();
        n0 = cyc;
        bus.word_in    = 32'h0000_00A5;
        bus.word_valid = 1'b1;
        tick();
        bus.word_valid = 1'b0;
        checks++;
        if (bus.fifo_level !== 3'd1) begin
            errors++;
            $display("FAIL lat_level_n1 got=%0d exp=1", bus.fifo_level);
        end
        tick();
        checks++;
        if (bus.cmd_data !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL lat_cmd_n2 got=%h exp=a5", bus.cmd_data);
        end
        checks++;
        if (bus.fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL lat_level_n2 got=%0d exp=0", bus.fifo_level);
        end
        checks++;
        if (bus.latch_data !== 1'b0) begin
            errors++;
            $display("FAIL lat_latch_n2 got=%b exp=0", bus.latch_data);
        end
        tick();
        checks++;
        if (bus.latch_data !== 1'b1) begin
            errors++;
            $display("FAIL lat_latch_n3 got=%b exp=1", bus.latch_data);
        end
        tick();
        checks++;
        if (bus.latch_data !== 1'b0) begin
            errors++;
            $display("FAIL lat_latch_n4 got=%b exp=0", bus.latch_data);
        end
        checks++;
        if (bus.cmd_data !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL lat_cmd_gap got=%h exp=a5", bus.cmd_data);
        end
        idle(4);
        checks++;
        if (sq_cyc.size() !== 1 || sq_cyc[0] !== n0 + 3) begin
            errors++;
            $display("FAIL lat_strobe_cycle got_n=%0d exp one at %0d",
                     sq_cyc.size(), n0 + 3);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_w[4];
        exp_w[0] = 32'h11; exp_w[1] = 32'h22;
        exp_w[2] = 32'h33; exp_w[3] = 32'h44;
        bus.sink_ready = 1'b0;
        tick();
        clear_log();
        for (int i = 0; i < 4; i++) push_word(exp_w[i]);
        push_word(32'h55);
        checks++;
        if (bus.fifo_level !== 3'd4) begin
            errors++;
            $display("FAIL ovf_level got=%0d exp=4", bus.fifo_level);
        end
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag got=%b exp=1", bus.overflow);
        end
        idle(3);
        checks++;
        if (sq_data.size() !== 0) begin
            errors++;
            $display("FAIL ovf_no_strobe got=%0d exp=0", sq_data.size());
        end
        bus.sink_ready = 1'b1;
        idle(30);
        checks++;
        if (sq_data.size() !== 4) begin
            errors++;
            $display("FAIL ovf_count got=%0d exp=4", sq_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (sq_data[i] !== exp_w[i]) begin
                    errors++;
                    $display("FAIL ovf_order[%0d] got=%h exp=%h",
                             i, sq_data[i], exp_w[i]);
                end
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (sq_cyc[i] - sq_cyc[i-1] !== 5) begin
                    errors++;
                    $display("FAIL ovf_spacing[%0d] got=%0d exp=5",
                             i, sq_cyc[i] - sq_cyc[i-1]);
                end
            end
        end
        bus.status_clear = 1'b1;
        tick();
        bus.status_clear = 1'b0;
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got=%b exp=0", bus.overflow);
        end
    endtask

    task automatic test_sticky_clear();
        bus.sink_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) push_word(32'h10 + 32'(i));
        push_word(32'h66);
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL stk_set got=%b exp=1", bus.overflow);
        end
        bus.status_clear = 1'b1;
        push_word(32'h77);
        bus.status_clear = 1'b0;
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL stk_drop_wins got=%b exp=1", bus.overflow);
        end
        bus.status_clear = 1'b1;
        tick();
        bus.status_clear = 1'b0;
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL stk_clear got=%b exp=0", bus.overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp_w[5];
        exp_w[0] = 32'h10; exp_w[1] = 32'h11; exp_w[2] = 32'h12;
        exp_w[3] = 32'h13; exp_w[4] = 32'hE5;
        clear_log();
        bus.sink_ready = 1'b1;
        bus.word_in    = 32'hE5;
        bus.word_valid = 1'b1;
        tick();
        bus.word_valid = 1'b0;
        checks++;
        if (bus.fifo_level !== 3'd4) begin
            errors++;
            $display("FAIL pp_level got=%0d exp=4", bus.fifo_level);
        end
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL pp_ovf got=%b exp=0", bus.overflow);
        end
        idle(35);
        checks++;
        if (sq_data.size() !== 5) begin
            errors++;
            $display("FAIL pp_count got=%0d exp=5", sq_data.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (sq_data[i] !== exp_w[i]) begin
                    errors++;
                    $display("FAIL pp_order[%0d] got=%h exp=%h",
                             i, sq_data[i], exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_strobe();
        bit found = 1'b0;
        bus.sink_ready = 1'b0;
        tick();
        push_word(32'hA1);
        push_word(32'hA2);
        push_word(32'hA3);
        bus.sink_ready = 1'b1;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (bus.latch_data === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rms_wait_strobe got=none exp=strobe");
        end
        checks++;
        if (bus.fifo_level !== 3'd2) begin
            errors++;
            $display("FAIL rms_level_pre got=%0d exp=2", bus.fifo_level);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.latch_data !== 1'b0) begin
            errors++;
            $display("FAIL rms_async_latch got=%b exp=0", bus.latch_data);
        end
        checks++;
        if (bus.fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL rms_async_level got=%0d exp=0", bus.fifo_level);
        end
        checks++;
        if (bus.cmd_data !== 32'h0) begin
            errors++;
            $display("FAIL rms_async_cmd got=%h exp=0", bus.cmd_data);
        end
        tick();
        reset = 1'b0;
        clear_log();
        idle(15);
        checks++;
        if (sq_data.size() !== 0) begin
            errors++;
            $display("FAIL rms_no_strobe got=%0d exp=0", sq_data.size());
        end
        checks++;
        if (bus.fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL rms_level_post got=%0d exp=0", bus.fifo_level);
        end
    endtask

    task automatic test_parity();
        bus.sink_ready = 1'b1;
        clear_log();
        push_word(32'h0000_0001);
`ifdef SPI_CMD_FIFO_PARITY_EN
        checks++;
        if (bus.parity_error !== 1'b1) begin
            errors++;
            $display("FAIL par_set got=%b exp=1", bus.parity_error);
        end
        checks++;
        if (bus.fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL par_level got=%0d exp=0", bus.fifo_level);
        end
        push_word(32'h0000_0003);
        idle(8);
        checks++;
        if (sq_data.size() !== 1 || sq_data[0] !== 32'h3) begin
            errors++;
            $display("FAIL par_good_word got_n=%0d exp one 0x3",
                     sq_data.size());
        end
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL par_no_ovf got=%b exp=0", bus.overflow);
        end
        bus.status_clear = 1'b1;
        tick();
        bus.status_clear = 1'b0;
        checks++;
        if (bus.parity_error !== 1'b0) begin
            errors++;
            $display("FAIL par_clear got=%b exp=0", bus.parity_error);
        end
`else
        idle(8);
        checks++;
        if (sq_data.size() !== 1 || sq_data[0] !== 32'h1) begin
            errors++;
            $display("FAIL par_off_word got_n=%0d exp one 0x1",
                     sq_data.size());
        end
        checks++;
        if (bus.parity_error !== 1'b0) begin
            errors++;
            $display("FAIL par_off_flag got=%b exp=0", bus.parity_error);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_latency();
        test_overflow();
        test_sticky_clear();
        test_full_push_pop();
        test_reset_mid_strobe();
        test_parity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
